// File: rtl/abm_load_scheduler_if.sv
// Request and loader-side signals of the ABM load scheduler.
// A request transfers on a rising clk edge where req_valid and req_ready are both 1; req_addr must be stable while req_valid is high.
interface abm_load_scheduler_if;
  logic [63:0] req_addr;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] pci_src_addr;
  logic        load;
  logic        load_wstrobe;
  logic        loader_idle;

  modport slave (
    input  req_addr, req_valid, loader_idle,
    output req_ready, pci_src_addr, load, load_wstrobe
  );

  modport master (
    output req_addr, req_valid, loader_idle,
    input  req_ready, pci_src_addr, load, load_wstrobe
  );
endinterface

// File: rtl/abm_load_scheduler.sv
// Queues host source addresses and sequences them into the ABM loader one at a time.
// Optional done watchdog: define ABM_SCHED_TIMEOUT_EN.
module abm_load_scheduler #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned START_WAIT     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
  input  logic                     clk,
  input  logic                     resetn,
  abm_load_scheduler_if.slave      bus,
  input  logic                     flush,
  input  logic                     err_clear,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [31:0]              done_count,
  output logic                     done_pulse,
  output logic [2:0]               error,
  output logic [1:0]               state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(START_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [63:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [SW-1:0]   sw_cnt;
  logic            ready_en;
  logic            push, push_keep, zero_drop;
  logic            pop, start_fail, done_evt, timeout_evt;
  logic [63:0]     addr_q;
  logic            load_q;

  assign state_dbg = state;

  // ready_en holds req_ready low until the first edge after reset release
  assign bus.req_ready    = ready_en & (queue_count < CW'(DEPTH)) & ~flush;
  assign push             = bus.req_valid & bus.req_ready;
  assign zero_drop        = push & (bus.req_addr == 64'd0);
  assign push_keep        = push & ~zero_drop;
  assign bus.pci_src_addr = addr_q;
  assign bus.load         = load_q;
  assign bus.load_wstrobe = load_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (queue_count != '0 && bus.loader_idle) state_next = S_ISSUE;
      S_ISSUE:      state_next = S_WAIT_START;
      S_WAIT_START: begin
        if (!bus.loader_idle)                    state_next = S_WAIT_DONE;
        else if (sw_cnt == SW'(START_WAIT - 1))  state_next = S_IDLE;
      end
      S_WAIT_DONE:  if (bus.loader_idle) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    start_fail = 1'b0;
    done_evt   = 1'b0;
    case (state)
      S_IDLE:       pop        = (state_next == S_ISSUE);
      S_WAIT_START: start_fail = (state_next == S_IDLE);
      S_WAIT_DONE:  done_evt   = (state_next == S_IDLE);
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_keep) mem[wr_ptr] <= bus.req_addr;
  end

  // A flush equalises the pointers; a coinciding pop still captures the head below
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        rd_ptr      <= wr_ptr;
        queue_count <= '0;
      end else begin
        if (push_keep) wr_ptr <= wr_ptr + 1'b1;
        if (pop)       rd_ptr <= rd_ptr + 1'b1;
        queue_count <= queue_count + CW'(push_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_cnt     <= '0;
      addr_q     <= '0;
      load_q     <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      done_count <= '0;
      error      <= '0;
    end else begin
      sw_cnt     <= (state == S_WAIT_START) ? sw_cnt + 1'b1 : '0;
      if (pop) addr_q <= mem[rd_ptr];
      load_q     <= (state_next == S_ISSUE);
      busy       <= (state_next != S_IDLE);
      done_pulse <= done_evt;
      done_count <= done_count + 32'(done_evt);
      // Same-cycle error events win over err_clear
      error      <= (error & {3{~err_clear}}) | {timeout_evt, start_fail, zero_drop};
    end
  end

`ifdef ABM_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Saturates at the limit so error[2] fires once per load
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     wd_cnt <= '0;
    else if (state != S_WAIT_DONE)   wd_cnt <= '0;
    else if (wd_cnt != TIMEOUT_CYCLES) wd_cnt <= wd_cnt + 32'd1;
  end

  assign timeout_evt = (state == S_WAIT_DONE) && (wd_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_abm_load_scheduler.sv
// Bench for abm_load_scheduler: loader model, address scoreboard and directed plus random scenarios.
`timescale 1ns/1ps
module tb_abm_load_scheduler;
  localparam int          DEPTH      = 4;
  localparam int          START_WAIT = 16;
  localparam logic [31:0] TMO        = 32'd50;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        err_clear = 1'b0;
  logic        busy, done_pulse;
  logic [2:0]  queue_count;
  logic [31:0] done_count;
  logic [2:0]  error;
  logic [1:0]  state_dbg;

  abm_load_scheduler_if bus();

  abm_load_scheduler #(.DEPTH(DEPTH), .START_WAIT(START_WAIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .flush(flush), .err_clear(err_clear),
    .busy(busy), .queue_count(queue_count), .done_count(done_count),
    .done_pulse(done_pulse), .error(error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [63:0] exp_q[$];
  int          exp_done = 0;
  logic [2:0]  exp_err = 3'b000;
  int          strobes = 0;

  int lm_lo = 2, lm_busy = 10;
  bit lm_rand = 0, lm_fail_next = 0, lm_active = 0, prev_load = 0;
  int lm_t, cur_lo, cur_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Loader model and strobe scoreboard, both sampled on the falling edge
  initial begin
    bus.loader_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.loader_idle = 1'b1;
        lm_active = 0;
        prev_load = 0;
      end else begin
        if (bus.load) begin
          strobes++;
          check("strobe_1cyc", prev_load, 0);
          check("wstrobe", bus.load_wstrobe, 1);
          check("load_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("load_addr", bus.pci_src_addr, exp_q.pop_front());
          if (lm_fail_next) begin
            lm_fail_next = 0;
          end else begin
            lm_active = 1;
            lm_t = 0;
            cur_lo   = lm_rand ? $urandom_range(3, 1)  : lm_lo;
            cur_busy = lm_rand ? $urandom_range(30, 1) : lm_busy;
          end
        end else if (lm_active) begin
          lm_t++;
          if (lm_t == cur_lo) bus.loader_idle = 1'b0;
          else if (lm_t == cur_lo + cur_busy) begin
            bus.loader_idle = 1'b1;
            lm_active = 0;
            exp_done++;
          end
        end
        if (done_pulse) check("done_count_at_pulse", done_count, exp_done);
        prev_load = bus.load;
      end
    end
  end

  task automatic enq(input logic [63:0] a);
    int n = 0;
    @(negedge clk);
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("enq_ready_wait", n < 2000, 1);
    if (a == 64'd0) exp_err[0] = 1'b1;
    else            exp_q.push_back(a);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.load && n < 500);
    check({tag, "_strobe_seen"}, n < 500, 1);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !lm_active && !busy) && n < 5000);
    check({tag, "_settle"}, n < 5000, 1);
    check({tag, "_qcount"}, queue_count, 0);
    check({tag, "_done_count"}, done_count, exp_done);
    check({tag, "_error"}, error, exp_err);
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    exp_err = 3'b000;
    check("err_clear", error, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_qcount"}, queue_count, 0);
    check({tag, "_done_count"}, done_count, 0);
    check({tag, "_done_pulse"}, done_pulse, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_load"}, bus.load, 0);
    check({tag, "_wstrobe"}, bus.load_wstrobe, 0);
    check({tag, "_addr"}, bus.pci_src_addr, 0);
    check({tag, "_ready"}, bus.req_ready, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int s0, d0, n;
    logic [63:0] a;
    bus.req_addr  = '0;
    bus.req_valid = 1'b0;

    // Reset and first-cycle ready
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    #1 check("ready_at_release", bus.req_ready, 0);
    @(negedge clk);
    check("ready_after_release", bus.req_ready, 1);

    // Single load with exact strobe timing
    lm_lo = 2; lm_busy = 100; s0 = strobes;
    @(negedge clk);
    bus.req_addr = 64'h1_0000_0000; bus.req_valid = 1'b1;
    exp_q.push_back(64'h1_0000_0000);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("single_qcount_1", queue_count, 1);
    check("single_no_load_yet", bus.load, 0);
    @(negedge clk);
    check("single_load_high", bus.load, 1);
    check("single_addr", bus.pci_src_addr, 64'h1_0000_0000);
    check("single_qcount_0", queue_count, 0);
    @(negedge clk);
    check("single_load_low", bus.load, 0);
    check("single_busy", busy, 1);
    wait_quiet("single");
    check("single_strobes", strobes - s0, 1);

    // Fill the queue behind an in-flight load
    lm_busy = 150; s0 = strobes; d0 = exp_done;
    for (int i = 0; i < 5; i++) enq({32'hF000_0000, 32'(i + 1) << 8});
    check("fill_ready_low", bus.req_ready, 0);
    check("fill_qcount", queue_count, DEPTH);
    wait_quiet("fill");
    check("fill_strobes", strobes - s0, 5);
    check("fill_done_delta", done_count - d0, 5);

    // Zero address dropped with error[0]
    lm_busy = 5; s0 = strobes;
    enq(64'd0);
    enq(64'h2000);
    wait_quiet("zero");
    check("zero_strobes", strobes - s0, 1);
    clear_errors();
    @(negedge clk);
    bus.req_addr = 64'd0; bus.req_valid = 1'b1; err_clear = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; err_clear = 1'b0;
    check("zero_beats_clear", error, 3'b001);
    exp_err = 3'b001;
    clear_errors();

    // Start failure then the next entry issues
    lm_fail_next = 1; lm_busy = 10; s0 = strobes; d0 = exp_done;
    fork
      begin
        enq(64'hA000_0000);
        enq(64'hB000_0000);
      end
      begin
        wait_strobe("sfail");
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!error[1] && n < 100);
        check("sfail_latency", n, START_WAIT + 1);
      end
    join
    exp_err[1] = 1'b1;
    wait_quiet("sfail");
    check("sfail_strobes", strobes - s0, 2);
    check("sfail_done_delta", exp_done - d0, 1);
    clear_errors();

    // Flush while a load is in flight
    lm_busy = 60; d0 = done_count;
    enq(64'h3000);
    enq(64'h4000);
    enq(64'h5000);
    enq(64'h6000);
    @(negedge clk);
    flush = 1'b1;
    exp_q.delete();
    #1 check("flush_ready_low", bus.req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_qcount", queue_count, 0);
    s0 = strobes;
    wait_quiet("flush");
    repeat (20) @(negedge clk);
    check("flush_no_strobes", strobes - s0, 0);
    check("flush_done_delta", done_count - d0, 1);

    // Randomized traffic
    lm_rand = 1;
    for (int i = 0; i < 14; i++) begin
      a = ($urandom_range(7, 0) == 0) ? 64'd0 : {$urandom, $urandom};
      enq(a);
      repeat ($urandom_range(6, 0)) @(negedge clk);
    end
    wait_quiet("rand");
    clear_errors();
    lm_rand = 0;

    // Long load: watchdog fires only when enabled
    lm_lo = 2; lm_busy = 80; d0 = exp_done;
    fork
      enq(64'hC000_0000);
      wait_strobe("wd");
    join
    repeat (45) @(negedge clk);
    check("wd_early", error[2], 0);
    repeat (15) @(negedge clk);
`ifdef ABM_SCHED_TIMEOUT_EN
    exp_err[2] = 1'b1;
`endif
    check("wd_state", error[2], exp_err[2]);
    check("wd_no_done_yet", done_count, d0);
    wait_quiet("wd");
    clear_errors();

    // Reset in the middle of a load
    fork
      enq(64'hD000_0000);
      wait_strobe("mrst");
    join
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1 check_reset_outputs("mrst");
    exp_q.delete();
    exp_done = 0;
    exp_err = 3'b000;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    lm_busy = 8;
    enq(64'hE000);
    wait_quiet("after_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
